array_input_ctrl: RTL
=====================

Name: array_input_ctrl

Overview:
Controller that sequences the switch/button array-entry block: lets the user pick an element count, enables array entry, captures the finished array and hands it to downstream logic over a valid/ready handshake. It sits between the debounced button decoder and the array-entry datapath, and owns that datapath's enable and target-count inputs. Abort and back-navigation are driven by the same 3-bit button codes.

Parameters:
MAX_COUNT, 4, largest legal element count (array holds 4 x 5-bit slots)
DATA_W, 20, width of captured array (4 x 5 bits, slot value 31 = empty)
TIMEOUT_CYCLES, 100_000_000, idle-entry timeout in clk cycles (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
press  in  3  button code, one-cycle pulse: 000 nxt, 001 rls, 010 con, 011 del, 100 ris, 111 none
count_sel  in  3  requested element count from switches
arr_over  in  1  array-entry block done pulse
arr_data  in  DATA_W  array-entry block packed output
arr_en  out  1  enable to array-entry block (low clears it)
arr_target  out  4  target count to array-entry block
out_valid  out  1  captured array available
out_ready  in  1  downstream accepts
out_data  out  DATA_W  captured array
out_count  out  3  element count of out_data
state_o  out  2  current state for display: 00 IDLE, 01 SEL, 10 INPUT, 11 DONE
err  out  1  one-cycle error pulse
err_code  out  2  01 bad count, 10 timeout; held until next err
xfer_cnt  out  8  completed transfers, wraps 255->0

Behaviour:
- Reset (async, any state): state IDLE; arr_en 0, arr_target 0, out_valid 0, out_data 0, out_count 0, err 0, err_code 00, xfer_cnt 0. All outputs registered.
- IDLE: arr_en 0. press==con -> SEL. Other codes ignored.
- SEL: press==con samples count_sel. If 1..MAX_COUNT: arr_target<=count_sel, -> INPUT. Otherwise err pulses 1 cycle, err_code<=01, stay in SEL. press==rls -> IDLE.
- INPUT: arr_en 1 from the first cycle in INPUT (registered with the state change). arr_target held constant.
  - arr_over==1 -> out_data<=arr_data, out_count<=arr_target[2:0], -> DONE. arr_en drops on the same edge.
  - press==rls -> IDLE; press==ris -> SEL. In both cases arr_en drops so the datapath clears.
  - nxt/del/con pass through to the datapath with no state effect.
  - arr_over and rls/ris in the same cycle: arr_over wins (capture, -> DONE).
- DONE: out_valid 1; out_data and out_count stable while out_valid is high.
  - out_valid && out_ready -> IDLE; out_valid 0 next cycle; xfer_cnt+1.
  - press==rls without ready -> IDLE, out_valid drops, no count.
  - ready and rls in the same cycle: counted as a transfer.
  - Other presses ignored.
- arr_over outside INPUT is ignored.
- Latency: con in SEL -> arr_en high at +1 cycle. arr_over -> out_valid high at +1 cycle.
- err is never high for two consecutive cycles per event. err_code is not cleared by state changes, only by reset.

Optional Feature:
INPUT_TIMEOUT_EN
- Defined: a counter (width ceil(log2(TIMEOUT_CYCLES+1))) runs in INPUT and resets on any press != none and on entering INPUT. On reaching TIMEOUT_CYCLES-1 with no press: -> IDLE, arr_en drops, err pulses, err_code<=10. If arr_over arrives in the same cycle, arr_over wins.
- Not defined: no counter, and INPUT waits indefinitely.

Test Plan:
- Reset mid-DONE with out_valid 1 -> all outputs at reset values immediately, state_o 00.
- con, count_sel=3, con -> arr_en 1 next cycle, arr_target 3. Drive arr_over with arr_data=0x0443F. -> out_valid 1 next cycle, out_data 0x0443F, out_count 3. With out_ready 1 -> xfer_cnt 1, state_o 00.
- In SEL, count_sel=0 and then 5 with con each time -> two single-cycle err pulses, err_code 01, state_o stays 01, arr_en 0.
- In INPUT, press=ris -> state_o 01, arr_en 0. Then press=rls -> state_o 00.
- In DONE, out_ready 0 for 10 cycles -> out_valid and out_data stable. Then out_ready 1 and rls in the same cycle -> xfer_cnt increments, state_o 00.
- With INPUT_TIMEOUT_EN and TIMEOUT_CYCLES=16: enter INPUT with no presses -> after 16 cycles state_o 00, err pulse, err_code 10. Same run with press=nxt at cycle 10 -> no timeout before cycle 26.

Source files
------------

// File: rtl/array_input_ctrl.sv
// Sequencing controller for the switch/button array-entry block: count select, entry, capture, hand-off.
// Optional idle-entry timeout in INPUT is compiled in when INPUT_TIMEOUT_EN is defined.
module array_input_ctrl #(
    parameter int MAX_COUNT      = 4,
    parameter int DATA_W         = 20,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        press,
    input  logic [2:0]        count_sel,
    input  logic              arr_over,
    input  logic [DATA_W-1:0] arr_data,
    output logic              arr_en,
    output logic [3:0]        arr_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_count,
    output logic [1:0]        state_o,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        xfer_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SEL   = 2'b01;
    localparam logic [1:0] ST_INPUT = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [2:0] P_NXT  = 3'b000;
    localparam logic [2:0] P_RLS  = 3'b001;
    localparam logic [2:0] P_CON  = 3'b010;
    localparam logic [2:0] P_DEL  = 3'b011;
    localparam logic [2:0] P_RIS  = 3'b100;
    localparam logic [2:0] P_NONE = 3'b111;

    localparam logic [3:0] MAX_CNT_L = 4'(MAX_COUNT);

    localparam logic [1:0] EC_BAD_COUNT = 2'b01;
    localparam logic [1:0] EC_TIMEOUT   = 2'b10;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       sel_ok;
    logic       bad_cnt;
    logic       capture;
    logic       xfer;
    logic       timeout;
    logic       timeout_hit;
    logic       count_ok;

    assign count_ok = (count_sel != 3'd0) && ({1'b0, count_sel} <= MAX_CNT_L);
    assign state_o  = state;

`ifdef INPUT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt;

    // Counter restarts on every real press and whenever INPUT is not the current state,
    // so it is always zero on the first INPUT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state != ST_INPUT || press != P_NONE) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ST_INPUT) && (press == P_NONE) && (idle_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Output handshake: a word moves when out_valid && out_ready on a rising clk edge.
    // out_valid, out_data and out_count are held unchanged until then (or until rls aborts).
    always_comb begin
        state_nxt = state;
        sel_ok    = 1'b0;
        bad_cnt   = 1'b0;
        capture   = 1'b0;
        xfer      = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press == P_CON) state_nxt = ST_SEL;
            end
            ST_SEL: begin
                if (press == P_CON) begin
                    if (count_ok) begin
                        sel_ok    = 1'b1;
                        state_nxt = ST_INPUT;
                    end else begin
                        bad_cnt = 1'b1;
                    end
                end else if (press == P_RLS) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_INPUT: begin
                // A finished array is never discarded, even when an abort arrives alongside it.
                if (arr_over) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (timeout_hit) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (press == P_RLS) begin
                    state_nxt = ST_IDLE;
                end else if (press == P_RIS) begin
                    state_nxt = ST_SEL;
                end
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    xfer      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (press == P_RLS) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            arr_en     <= 1'b0;
            arr_target <= 4'd0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= 3'd0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            xfer_cnt   <= 8'd0;
        end else begin
            state     <= state_nxt;
            arr_en    <= (state_nxt == ST_INPUT);
            out_valid <= (state_nxt == ST_DONE);
            err       <= bad_cnt | timeout;
            if (sel_ok) arr_target <= {1'b0, count_sel};
            if (capture) begin
                out_data  <= arr_data;
                out_count <= arr_target[2:0];
            end
            if (bad_cnt) begin
                err_code <= EC_BAD_COUNT;
            end else if (timeout) begin
                err_code <= EC_TIMEOUT;
            end
            if (xfer) xfer_cnt <= xfer_cnt + 8'd1;
        end
    end

    // nxt and del only matter to the datapath; named here so the code map stays complete.
    logic unused_codes;
    assign unused_codes = (press == P_NXT) | (press == P_DEL);

endmodule
